// File: rtl/tb_status_responder.sv
// Memory-mapped bench status responder: stdout FIFO, cycle counter and sticky
// pass/fail/exit indications that wait for buffered stdout to drain.
module tb_status_responder #(
    parameter logic [31:0] BASE_ADDR  = 32'h2000_0000,
    parameter int          FIFO_DEPTH = 8,
    parameter logic [31:0] PASS_MAGIC = 32'd123456789,
    parameter logic [31:0] FAIL_MAGIC = 32'd1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    output logic        gnt_o,
    input  logic [31:0] addr_i,
    input  logic        we_i,
    input  logic [3:0]  be_i,
    input  logic [31:0] wdata_i,
    output logic        rvalid_o,
    output logic [31:0] rdata_o,
    output logic        char_valid_o,
    output logic [7:0]  char_o,
    input  logic        char_ready_i,
    output logic        tests_passed_o,
    output logic        tests_failed_o,
    output logic        exit_valid_o,
    output logic [31:0] exit_value_o
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [AW:0] DEPTH_L = (AW + 1)'(FIFO_DEPTH);

    localparam logic [2:0] REG_STDOUT = 3'd0;
    localparam logic [2:0] REG_STATUS = 3'd1;
    localparam logic [2:0] REG_EXIT   = 3'd2;
    localparam logic [2:0] REG_CYCLES = 3'd3;
    localparam logic [2:0] REG_LEVEL  = 3'd4;

    typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_DONE} state_t;
    typedef enum logic [1:0] {PEND_NONE, PEND_PASS, PEND_FAIL, PEND_EXIT} pend_t;

    // Address decode: the window is 32 bytes, byte offset bits are don't-care.
    logic [31:0] offset;
    logic        in_window;
    logic [2:0]  reg_idx;
    logic        unused_addr;

    assign offset      = addr_i - BASE_ADDR;
    assign in_window   = (offset[31:5] == 27'd0);
    assign reg_idx     = offset[4:2];
    assign unused_addr = ^offset[1:0];

    logic sel_stdout, sel_status, sel_exit;
    assign sel_stdout = in_window && (reg_idx == REG_STDOUT);
    assign sel_status = in_window && (reg_idx == REG_STATUS);
    assign sel_exit   = in_window && (reg_idx == REG_EXIT);

    // Stdout FIFO
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   level;
    logic          empty, full, push_req, push, pop, stall;

    assign empty    = (level == '0);
    assign full     = (level == DEPTH_L);
    assign pop      = !empty && char_ready_i;
    assign push_req = req_i && we_i && sel_stdout && be_i[0];
    // A push into a full FIFO waits unless a pop frees the slot this cycle.
    assign stall    = push_req && full && !pop;
    assign gnt_o    = req_i && !stall;
    assign push     = push_req && !stall;

    assign char_valid_o = !empty;
    assign char_o       = empty ? 8'h00 : mem[rd_ptr];

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr] <= wdata_i[7:0];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    // Free-running cycle counter
    logic [31:0] cycle_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cycle_q <= '0;
        end else begin
            cycle_q <= cycle_q + 32'd1;
        end
    end

    // Read mux and registered response
    logic [31:0] rd_mux;

    always_comb begin
        rd_mux = '0;
        if (!we_i && in_window) begin
            case (reg_idx)
                REG_CYCLES: rd_mux = cycle_q;
                REG_LEVEL:  rd_mux = {{(31 - AW){1'b0}}, level};
                default:    rd_mux = '0;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rvalid_o <= 1'b0;
            rdata_o  <= '0;
        end else begin
            rvalid_o <= gnt_o;
            rdata_o  <= (gnt_o && !we_i) ? rd_mux : '0;
        end
    end

    // End-of-test FSM
    logic   status_wr, exit_wr;
    state_t state_q, state_d;
    pend_t  pend_q, pend_d;
    logic [31:0] exit_val_q, exit_val_d;

    assign status_wr = gnt_o && we_i && sel_status && (be_i == 4'hF);
    assign exit_wr   = gnt_o && we_i && sel_exit && (be_i == 4'hF);

    always_comb begin
        state_d    = state_q;
        pend_d     = pend_q;
        exit_val_d = exit_val_q;
        case (state_q)
            ST_RUN: begin
                if (status_wr && (wdata_i == PASS_MAGIC)) begin
                    pend_d  = PEND_PASS;
                    state_d = ST_DRAIN;
                end else if (status_wr && (wdata_i == FAIL_MAGIC)) begin
                    pend_d  = PEND_FAIL;
                    state_d = ST_DRAIN;
                end else if (exit_wr) begin
                    pend_d     = PEND_EXIT;
                    exit_val_d = wdata_i;
                    state_d    = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (empty) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_DONE;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_RUN;
            pend_q     <= PEND_NONE;
            exit_val_q <= '0;
        end else begin
            state_q    <= state_d;
            pend_q     <= pend_d;
            exit_val_q <= exit_val_d;
        end
    end

    // Status outputs are set on the DRAIN->DONE step and never cleared.
    logic enter_done;
    assign enter_done = (state_q == ST_DRAIN) && (state_d == ST_DONE);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tests_passed_o <= 1'b0;
            tests_failed_o <= 1'b0;
            exit_valid_o   <= 1'b0;
            exit_value_o   <= '0;
        end else if (enter_done) begin
            tests_passed_o <= (pend_q == PEND_PASS);
            tests_failed_o <= (pend_q == PEND_FAIL);
            exit_valid_o   <= (pend_q == PEND_EXIT);
            if (pend_q == PEND_EXIT) begin
                exit_value_o <= exit_val_q;
            end
        end
    end

endmodule
